// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core: load-use bubbles,
// redirect squash, memory-wait freeze, saturating perf counters, timeout flag.
module pipe_hazard_ctrl #(
  parameter int unsigned LOAD_LAT    = 1,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_memread_i,
  input  logic             ex_redirect_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_write_o,
  output logic             mem_wb_bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             mem_err_o
);

  typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT} state_t;

  localparam logic [2:0]  LAT_M1  = 3'(LOAD_LAT - 1);
  localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

  state_t           state_reg;
  logic [2:0]       stall_left_reg;
  logic [15:0]      wait_reg;
  logic [16:0]      wait_inc;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;
  logic             mem_err_reg;

  logic hz;
  logic mem_wait;
  logic stall_inc;
  logic flush_inc;

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign hz = ex_memread_i && (ex_rd_i != 5'd0) &&
              ((id_rs1_used_i && (id_rs1_i == ex_rd_i)) ||
               (id_rs2_used_i && (id_rs2_i == ex_rd_i)));
  assign mem_wait = mem_req_i && !mem_ready_i;
  assign wait_inc = {1'b0, wait_reg} + 17'd1;

  always_comb begin
    pc_write_o      = 1'b1;
    if_id_write_o   = 1'b1;
    if_id_flush_o   = 1'b0;
    id_ex_flush_o   = 1'b0;
    ex_mem_write_o  = 1'b1;
    mem_wb_bubble_o = 1'b0;
    stall_inc       = 1'b0;
    flush_inc       = 1'b0;
    if (!rst_i) begin
      case (state_reg)
        RUN: begin
          if (mem_wait) begin
            pc_write_o      = 1'b0;
            if_id_write_o   = 1'b0;
            ex_mem_write_o  = 1'b0;
            mem_wb_bubble_o = 1'b1;
            stall_inc       = 1'b1;
          end else if (ex_redirect_i) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            flush_inc     = 1'b1;
          end else if (hz) begin
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            id_ex_flush_o = 1'b1;
            stall_inc     = 1'b1;
          end
        end
        LOAD_STALL: begin
          stall_inc = 1'b1;
          if (mem_wait) begin
            pc_write_o      = 1'b0;
            if_id_write_o   = 1'b0;
            ex_mem_write_o  = 1'b0;
            mem_wb_bubble_o = 1'b1;
          end else begin
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            id_ex_flush_o = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!mem_ready_i) begin
            pc_write_o      = 1'b0;
            if_id_write_o   = 1'b0;
            ex_mem_write_o  = 1'b0;
            mem_wb_bubble_o = 1'b1;
            stall_inc       = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= RUN;
      stall_left_reg <= '0;
      wait_reg       <= '0;
      stall_cnt_reg  <= '0;
      flush_cnt_reg  <= '0;
      mem_err_reg    <= 1'b0;
    end else begin
      if (stall_inc && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (flush_inc && (flush_cnt_reg != '1)) flush_cnt_reg <= flush_cnt_reg + 1'b1;
      case (state_reg)
        RUN: begin
          if (mem_wait) begin
            state_reg <= MEM_WAIT;
            wait_reg  <= 16'd1;
            if (TIMEOUT <= 16'd1) mem_err_reg <= 1'b1;
          end else if (!ex_redirect_i && hz && (LOAD_LAT > 1)) begin
            state_reg      <= LOAD_STALL;
            stall_left_reg <= LAT_M1;
          end
        end
        LOAD_STALL: begin
          // A freeze here keeps the owed bubble count for after the access.
          if (mem_wait) begin
            state_reg <= MEM_WAIT;
            wait_reg  <= 16'd1;
            if (TIMEOUT <= 16'd1) mem_err_reg <= 1'b1;
          end else if (stall_left_reg <= 3'd1) begin
            state_reg      <= RUN;
            stall_left_reg <= '0;
          end else begin
            stall_left_reg <= stall_left_reg - 3'd1;
          end
        end
        MEM_WAIT: begin
          if (mem_ready_i) begin
            wait_reg  <= '0;
            state_reg <= (stall_left_reg != 3'd0) ? LOAD_STALL : RUN;
          end else begin
            if (wait_reg < TIMEOUT) wait_reg <= wait_reg + 16'd1;
            if (wait_inc >= {1'b0, TIMEOUT}) mem_err_reg <= 1'b1;
          end
        end
        default: state_reg <= RUN;
      endcase
    end
  end

  assign stall_cnt_o = stall_cnt_reg;
  assign flush_cnt_o = flush_cnt_reg;
  assign mem_err_o   = mem_err_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two parameterisations driven with shared stimulus,
// checked each cycle against a bubble/freeze accounting model plus literal checks.
module tb_pipe_hazard_ctrl;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic       rst_i;
  logic [4:0] id_rs1_i, id_rs2_i, ex_rd_i;
  logic       id_rs1_used_i, id_rs2_used_i, ex_memread_i, ex_redirect_i;
  logic       mem_req_i, mem_ready_i;

  logic        pc_a, ifw_a, iff_a, ief_a, exw_a, bub_a, err_a;
  logic [15:0] scnt_a, fcnt_a;
  logic        pc_b, ifw_b, iff_b, ief_b, exw_b, bub_b, err_b;
  logic [3:0]  scnt_b, fcnt_b;

  pipe_hazard_ctrl #(.LOAD_LAT(1), .MEM_TIMEOUT(3), .CNT_W(16)) dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i), .ex_rd_i(ex_rd_i),
    .ex_memread_i(ex_memread_i), .ex_redirect_i(ex_redirect_i), .mem_req_i(mem_req_i),
    .mem_ready_i(mem_ready_i), .pc_write_o(pc_a), .if_id_write_o(ifw_a),
    .if_id_flush_o(iff_a), .id_ex_flush_o(ief_a), .ex_mem_write_o(exw_a),
    .mem_wb_bubble_o(bub_a), .stall_cnt_o(scnt_a), .flush_cnt_o(fcnt_a), .mem_err_o(err_a));

  pipe_hazard_ctrl #(.LOAD_LAT(3), .MEM_TIMEOUT(6), .CNT_W(4)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i), .ex_rd_i(ex_rd_i),
    .ex_memread_i(ex_memread_i), .ex_redirect_i(ex_redirect_i), .mem_req_i(mem_req_i),
    .mem_ready_i(mem_ready_i), .pc_write_o(pc_b), .if_id_write_o(ifw_b),
    .if_id_flush_o(iff_b), .id_ex_flush_o(ief_b), .ex_mem_write_o(exw_b),
    .mem_wb_bubble_o(bub_b), .stall_cnt_o(scnt_b), .flush_cnt_o(fcnt_b), .mem_err_o(err_b));

  // Output vector order: {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_bubble}
  localparam logic [5:0] O_NORMAL = 6'b110010;
  localparam logic [5:0] O_FREEZE = 6'b000001;
  localparam logic [5:0] O_FLUSH  = 6'b111110;
  localparam logic [5:0] O_BUBBLE = 6'b000110;

  int chk_cnt  = 0;
  int fail_cnt = 0;

  // Reference model: bubbles still owed, whether a data access is outstanding,
  // how long it has been outstanding, and the three visible registered values.
  int owed[2]     = '{0, 0};
  bit in_wait[2]  = '{0, 0};
  int wlen[2]     = '{0, 0};
  int m_scnt[2]   = '{0, 0};
  int m_fcnt[2]   = '{0, 0};
  bit m_err[2]    = '{0, 0};
  bit mvalid      = 1'b0;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction
  function automatic int tmo_of(input int i);
    return (i == 0) ? 3 : 6;
  endfunction
  function automatic int cmax_of(input int i);
    return (i == 0) ? 65535 : 15;
  endfunction

  function automatic logic [5:0] act_out(input int i);
    return (i == 0) ? {pc_a, ifw_a, iff_a, ief_a, exw_a, bub_a}
                    : {pc_b, ifw_b, iff_b, ief_b, exw_b, bub_b};
  endfunction
  function automatic logic [31:0] act_scnt(input int i);
    return (i == 0) ? {16'd0, scnt_a} : {28'd0, scnt_b};
  endfunction
  function automatic logic [31:0] act_fcnt(input int i);
    return (i == 0) ? {16'd0, fcnt_a} : {28'd0, fcnt_b};
  endfunction
  function automatic logic act_err(input int i);
    return (i == 0) ? err_a : err_b;
  endfunction

  function automatic bit hz_now();
    return ex_memread_i && (ex_rd_i != 5'd0) &&
           ((id_rs1_used_i && (id_rs1_i == ex_rd_i)) || (id_rs2_used_i && (id_rs2_i == ex_rd_i)));
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", name, i, act, exp, $time);
    end
  endtask

  task automatic bump_stall(input int i);
    if (m_scnt[i] < cmax_of(i)) m_scnt[i]++;
  endtask

  task automatic model_step(input int i, input bit h, input bit mw, output logic [5:0] e);
    if (rst_i) begin
      e = O_NORMAL;
      owed[i] = 0; in_wait[i] = 0; wlen[i] = 0;
      m_scnt[i] = 0; m_fcnt[i] = 0; m_err[i] = 0;
    end else if (in_wait[i]) begin
      if (mem_ready_i) begin
        e = O_NORMAL; in_wait[i] = 0; wlen[i] = 0;
      end else begin
        e = O_FREEZE; bump_stall(i); wlen[i]++;
        if (wlen[i] >= tmo_of(i)) m_err[i] = 1;
      end
    end else if (mw) begin
      e = O_FREEZE; bump_stall(i); in_wait[i] = 1; wlen[i] = 1;
      if (wlen[i] >= tmo_of(i)) m_err[i] = 1;
    end else if (owed[i] > 0) begin
      e = O_BUBBLE; bump_stall(i); owed[i]--;
    end else if (ex_redirect_i) begin
      e = O_FLUSH;
      if (m_fcnt[i] < cmax_of(i)) m_fcnt[i]++;
    end else if (h) begin
      e = O_BUBBLE; bump_stall(i); owed[i] = lat_of(i) - 1;
    end else begin
      e = O_NORMAL;
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk_i) begin
    logic [5:0] e;
    bit h, mw;
    h  = hz_now();
    mw = mem_req_i && !mem_ready_i;
    for (int i = 0; i < 2; i++) begin
      if (mvalid) begin
        chk("stall_cnt", i, act_scnt(i), 32'(m_scnt[i]));
        chk("flush_cnt", i, act_fcnt(i), 32'(m_fcnt[i]));
        chk("mem_err", i, 32'(act_err(i)), 32'(m_err[i]));
      end
      model_step(i, h, mw, e);
      chk("ctrl_outputs", i, 32'(act_out(i)), 32'(e));
    end
    if (rst_i) mvalid = 1'b1;
  end

  task automatic idle();
    id_rs1_i = '0; id_rs2_i = '0; ex_rd_i = '0;
    id_rs1_used_i = 0; id_rs2_used_i = 0; ex_memread_i = 0;
    ex_redirect_i = 0; mem_req_i = 0; mem_ready_i = 0;
  endtask
  task automatic set_hz();
    ex_memread_i = 1; ex_rd_i = 5'd5; id_rs2_i = 5'd5; id_rs2_used_i = 1;
  endtask
  task automatic tick();
    @(posedge clk_i); #1;
  endtask
  task automatic mid();
    @(negedge clk_i);
  endtask
  task automatic do_reset();
    rst_i = 1; idle(); tick(); rst_i = 0;
  endtask

  initial begin
    int nb;
    rst_i = 1; idle(); set_hz();
    $display("txn reset with hazard active");
    mid();
    chk("rst_pc_write", 0, 32'(pc_a), 1);
    chk("rst_if_id_write", 0, 32'(ifw_a), 1);
    chk("rst_id_ex_flush", 0, 32'(ief_a), 0);
    tick(); mid();
    chk("rst_ex_mem_write", 1, 32'(exw_b), 1);
    tick(); rst_i = 0; idle();
    mid();
    chk("post_rst_stall_cnt", 0, {16'd0, scnt_a}, 0);
    chk("post_rst_flush_cnt", 0, {16'd0, fcnt_a}, 0);
    chk("post_rst_mem_err", 0, 32'(err_a), 0);
    chk("post_rst_pc_write", 0, 32'(pc_a), 1);

    $display("txn load-use rd=5");
    tick(); set_hz(); mid();
    chk("lu_pc_write", 0, 32'(pc_a), 0);
    chk("lu_if_id_write", 0, 32'(ifw_a), 0);
    chk("lu_id_ex_flush", 0, 32'(ief_a), 1);
    tick(); idle(); mid();
    chk("lu_release_pc_write", 0, 32'(pc_a), 1);
    chk("lu_stall_cnt", 0, {16'd0, scnt_a}, 1);
    repeat (4) tick();
    $display("txn load-use rd=0");
    set_hz(); ex_rd_i = 0; id_rs2_i = 0; mid();
    chk("x0_pc_write", 0, 32'(pc_a), 1);
    chk("x0_id_ex_flush", 0, 32'(ief_a), 0);
    tick(); idle(); mid();
    chk("x0_stall_cnt", 0, {16'd0, scnt_a}, 1);

    $display("txn redirect with hazard");
    tick(); do_reset(); set_hz(); ex_redirect_i = 1; mid();
    chk("rd_if_id_flush", 0, 32'(iff_a), 1);
    chk("rd_id_ex_flush", 0, 32'(ief_a), 1);
    chk("rd_pc_write", 0, 32'(pc_a), 1);
    tick(); idle(); mid();
    chk("rd_flush_cnt", 0, {16'd0, fcnt_a}, 1);
    chk("rd_stall_cnt", 0, {16'd0, scnt_a}, 0);

    $display("txn memory wait 4 cycles");
    tick(); do_reset();
    for (int k = 0; k < 4; k++) begin
      mem_req_i = 1; mem_ready_i = 0; mid();
      chk("mw_ex_mem_write", 0, 32'(exw_a), 0);
      chk("mw_bubble", 0, 32'(bub_a), 1);
      tick();
    end
    mem_req_i = 1; mem_ready_i = 1; mid();
    chk("mw_ready_pc_write", 0, 32'(pc_a), 1);
    chk("mw_ready_bubble", 0, 32'(bub_a), 0);
    tick(); idle(); mid();
    chk("mw_stall_cnt", 0, {16'd0, scnt_a}, 4);

    $display("txn memory timeout");
    tick(); do_reset();
    for (int k = 1; k <= 5; k++) begin
      mem_req_i = 1; mem_ready_i = 0; mid();
      if (k == 3) chk("to_err_before", 0, 32'(err_a), 0);
      if (k == 4) chk("to_err_after", 0, 32'(err_a), 1);
      tick();
    end
    mem_ready_i = 1; tick(); idle(); mid();
    chk("to_err_sticky", 0, 32'(err_a), 1);
    tick(); do_reset(); mid();
    chk("to_err_cleared", 0, 32'(err_a), 0);

    $display("txn LOAD_LAT=3 with memory wait in 2nd stall cycle");
    tick(); do_reset(); nb = 0;
    set_hz(); mid(); nb += int'(ief_b);
    chk("l3_first_pc_write", 1, 32'(pc_b), 0);
    tick(); idle(); mem_req_i = 1; mid(); nb += int'(ief_b);
    chk("l3_freeze_ex_mem_write", 1, 32'(exw_b), 0);
    repeat (2) begin tick(); mid(); nb += int'(ief_b); end
    tick(); mem_ready_i = 1; mid(); nb += int'(ief_b);
    chk("l3_ready_ex_mem_write", 1, 32'(exw_b), 1);
    tick(); idle(); mid(); nb += int'(ief_b);
    chk("l3_resume_pc_write", 1, 32'(pc_b), 0);
    tick(); mid(); nb += int'(ief_b);
    tick(); mid(); nb += int'(ief_b);
    chk("l3_done_pc_write", 1, 32'(pc_b), 1);
    chk("l3_bubbles", 1, 32'(nb), 3);
    chk("l3_stall_cnt", 1, {28'd0, scnt_b}, 6);

    $display("txn counter saturation");
    tick(); do_reset();
    repeat (20) begin set_hz(); tick(); end
    idle(); repeat (3) tick();
    repeat (20) begin ex_redirect_i = 1; tick(); end
    idle(); mid();
    chk("sat_stall_cnt_b", 1, {28'd0, scnt_b}, 15);
    chk("sat_stall_cnt_a", 0, {16'd0, scnt_a}, 20);
    chk("sat_flush_cnt_b", 1, {28'd0, fcnt_b}, 15);
    chk("sat_flush_cnt_a", 0, {16'd0, fcnt_a}, 20);

    $display("txn random phase 3000 cycles");
    tick();
    for (int n = 0; n < 3000; n++) begin
      rst_i         = ($urandom_range(0, 299) == 0);
      id_rs1_i      = 5'($urandom_range(0, 3));
      id_rs2_i      = 5'($urandom_range(0, 3));
      ex_rd_i       = 5'($urandom_range(0, 3));
      id_rs1_used_i = 1'($urandom_range(0, 1));
      id_rs2_used_i = 1'($urandom_range(0, 1));
      ex_memread_i  = ($urandom_range(0, 2) != 0);
      ex_redirect_i = ($urandom_range(0, 5) == 0);
      mem_req_i     = ($urandom_range(0, 3) == 0);
      mem_ready_i   = ($urandom_range(0, 2) == 0);
      tick();
    end
    rst_i = 0; idle(); mid();

    $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
    $finish;
  end

endmodule
